// File: rtl/time_set_pkg.sv
// Shared types and digit limits for the clock time-set input block.
// Digit order follows set_time: {Htens, Hunits, Mtens, Munits}.
package time_set_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] DIG_HT = 2'd3;
  localparam logic [1:0] DIG_HU = 2'd2;
  localparam logic [1:0] DIG_MT = 2'd1;
  localparam logic [1:0] DIG_MU = 2'd0;

  localparam logic [3:0] HT_MAX    = 4'd2;
  localparam logic [3:0] HU_MAX    = 4'd9;
  localparam logic [3:0] HU_MAX_H2 = 4'd3;
  localparam logic [3:0] MT_MAX    = 4'd5;
  localparam logic [3:0] MU_MAX    = 4'd9;

  function automatic logic [3:0] digit_max(
    input logic [1:0] idx,
    input logic [3:0] ht
  );
    unique case (idx)
      DIG_HT:  return HT_MAX;
      DIG_HU:  return (ht == 4'd2) ? HU_MAX_H2 : HU_MAX;
      DIG_MT:  return MT_MAX;
      default: return MU_MAX;
    endcase
  endfunction

endpackage

// File: rtl/time_set_input_if.sv
// Button inputs and edit/commit outputs of the time-set block.
// master drives buttons, slave is the time_set_input block.
interface time_set_input_if;
  logic        btn_mode;
  logic        btn_inc;
  logic        set_active;
  logic [1:0]  set_digit;
  logic [3:0]  set_value;
  logic        set_valid;
  logic [15:0] set_time;

  modport master (
    output btn_mode, btn_inc,
    input  set_active, set_digit, set_value,
    input  set_valid, set_time
  );

  modport slave (
    input  btn_mode, btn_inc,
    output set_active, set_digit, set_value,
    output set_valid, set_time
  );
endinterface

// File: rtl/debounce.sv
// Button synchronizer + stable-time debouncer with a press pulse
// emitted on the debounced 0->1 transition only.
module debounce #(
  parameter int DB_CYC = 2
) (
  input  logic hwclk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

  logic          s1;
  logic          s2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          done;

  assign done = (s2 != level) && (cnt == CW'(DB_CYC - 1));

  always_ff @(posedge hwclk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      press <= done && s2;
      if (done) begin
        level <= s2;
        cnt   <= '0;
      end else if (s2 != level) begin
        cnt   <= cnt + CW'(1);
      end else begin
        cnt   <= '0;
      end
    end
  end

endmodule

// File: rtl/time_set_input.sv
// Two-button HH:MM time setter: mode walks digits, inc bumps one.
// Define TIME_SET_TIMEOUT_EN to abandon an idle edit after TIMEOUT_S.
module time_set_input
  import time_set_pkg::*;
#(
  parameter int CLK_HZ      = 12000000,
  parameter int DEBOUNCE_MS = 20,
  parameter int TIMEOUT_S   = 10
) (
  input  logic hwclk,
  input  logic rst,
  time_set_input_if.slave bus
);

  localparam int DB_CYC = CLK_HZ / 1000 * DEBOUNCE_MS;

  state_t          state;
  state_t          state_nx;
  logic            mode_ev;
  logic            inc_ev;
  logic            to_hit;
  logic [3:0][3:0] wd;
  logic [1:0]      dig;
  logic [15:0]     time_q;

  debounce #(.DB_CYC(DB_CYC)) u_db_mode (
    .hwclk (hwclk),
    .rst   (rst),
    .btn   (bus.btn_mode),
    .press (mode_ev)
  );

  debounce #(.DB_CYC(DB_CYC)) u_db_inc (
    .hwclk (hwclk),
    .rst   (rst),
    .btn   (bus.btn_inc),
    .press (inc_ev)
  );

`ifdef TIME_SET_TIMEOUT_EN
  localparam int TO_CYC = TIMEOUT_S * CLK_HZ;
  localparam int TW     = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  logic [TW-1:0] to_cnt;

  always_ff @(posedge hwclk) begin
    if (rst || state != EDIT || mode_ev || inc_ev) to_cnt <= '0;
    else to_cnt <= to_cnt + TW'(1);
  end

  assign to_hit = (to_cnt == TW'(TO_CYC - 1)) && !(mode_ev || inc_ev);
`else
  wire unused_to = (TIMEOUT_S > 0);
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge hwclk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (mode_ev) state_nx = EDIT;
      EDIT: begin
        if (mode_ev && dig == DIG_MU) state_nx = COMMIT;
        else if (to_hit) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // mode outranks inc when both pulse in the same cycle
  always_ff @(posedge hwclk) begin
    if (rst) begin
      time_q <= '0;
      wd     <= '0;
      dig    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (mode_ev) begin
            wd  <= time_q;
            dig <= DIG_HT;
          end
        end
        EDIT: begin
          if (mode_ev) begin
            if (dig == DIG_MU) begin
              time_q <= wd;
            end else begin
              dig <= dig - 2'd1;
              if (dig == DIG_HT && wd[DIG_HT] == 4'd2
                  && wd[DIG_HU] > HU_MAX_H2)
                wd[DIG_HU] <= '0;
            end
          end else if (inc_ev) begin
            wd[dig] <= (wd[dig] >= digit_max(dig, wd[DIG_HT]))
                       ? 4'd0 : wd[dig] + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.set_active = 1'b0;
    bus.set_digit  = 2'd0;
    bus.set_value  = 4'd0;
    bus.set_valid  = 1'b0;
    unique case (state)
      EDIT: begin
        bus.set_active = 1'b1;
        bus.set_digit  = dig;
        bus.set_value  = wd[dig];
      end
      COMMIT: bus.set_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.set_time = time_q;

endmodule

// File: doc/time_set_input.md
TIME_SET_INPUT -- requirements
Module: time_set_input

Interface
REQ-001 Parameter CLK_HZ, default 12000000, hwclk frequency in Hz.
REQ-002 Parameter DEBOUNCE_MS, default 20, button stable time; DB_CYC = CLK_HZ/1000*DEBOUNCE_MS cycles.
REQ-003 Parameter TIMEOUT_S, default 10, edit inactivity timeout in seconds (used only with TIME_SET_TIMEOUT_EN).
REQ-004 hwclk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 btn_mode  in  1  raw asynchronous mode button, active-high.
REQ-007 btn_inc  in  1  raw asynchronous increment button, active-high.
REQ-008 set_active  out  1  high while a digit is being edited.
REQ-009 set_digit  out  2  index of the digit being edited: 3=hour tens, 2=hour units, 1=minute tens, 0=minute units.
REQ-010 set_value  out  4  BCD value of the digit being edited.
REQ-011 set_valid  out  1  one-cycle pulse when a new time is committed.
REQ-012 set_time  out  16  committed time, BCD {Htens, Hunits, Mtens, Munits}, held between commits.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer, then a debouncer whose level changes only after DB_CYC consecutive cycles of a differing synchronized input.
REQ-014 A press event SHALL be a one-cycle pulse on the 0->1 edge of the debounced level; releases produce no event.
REQ-015 FSM states SHALL be IDLE, EDIT and COMMIT.
REQ-016 IDLE + mode press -> EDIT with set_digit=3, and all four working digits loaded from set_time.
REQ-017 EDIT + inc press SHALL increment the current working digit, wrapping to 0 past its limit: Htens 2, Hunits 9 (3 when Htens==2), Mtens 5, Munits 9.
REQ-018 EDIT + mode press with set_digit>0 SHALL decrement set_digit; on 3->2, if Htens==2 and Hunits>3, Hunits SHALL be cleared to 0 in the same cycle.
REQ-019 EDIT + mode press with set_digit==0 -> COMMIT.
REQ-020 COMMIT SHALL last exactly one cycle: set_time takes the working digits, set_valid=1, then the FSM goes to IDLE; event latency from the mode press pulse to set_valid is 1 cycle.
REQ-021 Mode and inc press events in the same cycle: mode SHALL take effect and inc SHALL be discarded.
REQ-022 Press events in IDLE other than mode, and any event in COMMIT, SHALL be ignored.
REQ-023 set_active SHALL be 1 only in EDIT; set_value SHALL equal the working digit at set_digit; in IDLE, set_digit=0 and set_value=0.

Reset
REQ-024 On rst, the FSM SHALL enter IDLE, and set_time, working digits, set_digit, set_value, set_active, set_valid, synchronizers, debounce levels and debounce counters SHALL all clear to 0.
REQ-025 rst asserted mid-edit SHALL abandon the edit with no set_valid pulse.

Configuration
REQ-026 With TIME_SET_TIMEOUT_EN defined, EDIT SHALL return to IDLE after TIMEOUT_S*CLK_HZ cycles without a press event, with no set_valid and set_time unchanged; any press event SHALL restart the timer.
REQ-027 Without TIME_SET_TIMEOUT_EN, EDIT SHALL persist indefinitely and no timeout counter SHALL exist.

Structure
REQ-028 Package time_set_pkg SHALL hold the state type, digit index constants and per-digit limit constants.
REQ-029 The debouncer SHALL be the sub-module debounce, which contains the synchronizer, the counter and the edge pulse; it SHALL be instanced twice.

Verification (CLK_HZ=1000, DEBOUNCE_MS=2, so DB_CYC=2)
REQ-030 Bench case: btn_inc glitch high for 1 cycle -> no event; held high 5 cycles -> exactly one press pulse.
REQ-031 Bench case: from reset, mode press; inc x3 (Htens wraps 0,1,2,0); mode; inc x2; mode x3 -> one set_valid pulse, set_time=16'h0200.
REQ-032 Bench case: set Htens=1, Hunits=9; mode back to Htens; inc to 2; mode -> Hunits=0; inc x4 -> Hunits wraps 3 -> 0.
REQ-033 Bench case: mode and inc pressed in the same cycle while in EDIT -> set_digit decrements and the digit value is unchanged.
REQ-034 Bench case: rst pulsed during EDIT with set_digit=1 -> all outputs 0 on the next cycle and no set_valid.
REQ-035 Bench case: with TIME_SET_TIMEOUT_EN and TIMEOUT_S=1, idle in EDIT for 1000 cycles -> set_active falls and set_time is unchanged.
